// File: rtl/note_playback_sequencer.sv
// -----------------------------------------------------------------------------
// note_playback_sequencer
//
// Replays stored measures from the note memory at the selected tempo. Each
// 48-bit measure word holds eight eighth-note slots of NOTE_W bits each. One
// note code is presented per eighth, with a single-cycle strobe at the start
// of the eighth and a metronome click for the first CLICK_CYCLES cycles.
//
// Ports:
//   clk_2           in   system clock
//   rst_in          in   asynchronous active-high reset
//   play_in         in   level; high requests playback, low stops it
//   loop_in         in   sampled at the end of the last eighth; 1 = restart
//   bpm_in          in   tempo select (2'b10=120, 2'b01=80, else 60 bpm)
//   mem_addr_out    out  measure word address (spare read port)
//   mem_data_in     in   measure word; slot s = bits [s*NOTE_W +: NOTE_W]
//   note_out        out  current note code
//   note_valid_out  out  note_out MSB while playing (rests are 0)
//   note_strobe_out out  one-cycle pulse at the start of each eighth
//   eighth_idx_out  out  current eighth index
//   playing_out     out  high while playing
//   done_out        out  high once the last eighth has finished (no loop)
//   metronome_out   out  click pulse at the start of each eighth
//
// Read timing: data for an address driven at edge k is sampled by this block
// at edge k+RD_LATENCY.
// -----------------------------------------------------------------------------
module note_playback_sequencer #(
  parameter int MEAS_DEPTH   = 20,
  parameter int NOTE_W       = 6,
  parameter int RD_LATENCY   = 2,
  parameter int PERIOD_120   = 18562500,
  parameter int PERIOD_80    = 27843750,
  parameter int PERIOD_60    = 37125000,
  parameter int CLICK_CYCLES = 200000
) (
  input  logic                          clk_2,
  input  logic                          rst_in,
  input  logic                          play_in,
  input  logic                          loop_in,
  input  logic [1:0]                    bpm_in,
  output logic [$clog2(MEAS_DEPTH)-1:0] mem_addr_out,
  input  logic [8*NOTE_W-1:0]           mem_data_in,
  output logic [NOTE_W-1:0]             note_out,
  output logic                          note_valid_out,
  output logic                          note_strobe_out,
  output logic [7:0]                    eighth_idx_out,
  output logic                          playing_out,
  output logic                          done_out,
  output logic                          metronome_out
);

  localparam int ADDR_W = $clog2(MEAS_DEPTH);
  localparam int WORD_W = 8 * NOTE_W;
  localparam int LAT_W  = $clog2(RD_LATENCY + 1);

  localparam logic [31:0]       C_P120     = 32'(PERIOD_120);
  localparam logic [31:0]       C_P80      = 32'(PERIOD_80);
  localparam logic [31:0]       C_P60      = 32'(PERIOD_60);
  localparam logic [31:0]       C_CLICK    = 32'(CLICK_CYCLES);
  localparam logic [7:0]        C_LAST_IDX = 8'(8 * MEAS_DEPTH - 1);
  localparam logic [ADDR_W-1:0] C_ADDR_MAX = ADDR_W'(MEAS_DEPTH - 1);
  localparam logic [LAT_W-1:0]  C_LAT      = LAT_W'(RD_LATENCY);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_PLAY  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  // Eighth-note period in clk_2 cycles for a tempo select value.
  function automatic logic [31:0] period_sel(input logic [1:0] bpm);
    logic [31:0] p;
    case (bpm)
      2'b10:   p = C_P120;
      2'b01:   p = C_P80;
      default: p = C_P60;
    endcase
    return p;
  endfunction

  // Extract one note slot from a measure word.
  function automatic logic [NOTE_W-1:0] slot_of(input logic [WORD_W-1:0] w,
                                                input logic [2:0]        s);
    return w[s*NOTE_W +: NOTE_W];
  endfunction

  // Next word address with wrap at the end of the stored measures.
  function automatic logic [ADDR_W-1:0] addr_inc(input logic [ADDR_W-1:0] a);
    logic [ADDR_W-1:0] n;
    if (a == C_ADDR_MAX) begin
      n = '0;
    end else begin
      n = a + ADDR_W'(1);
    end
    return n;
  endfunction

  state_t              r_state;
  logic [ADDR_W-1:0]   r_addr;
  logic [WORD_W-1:0]   r_cur_word;
  logic [WORD_W-1:0]   r_next_word;
  logic [LAT_W-1:0]    r_rd_cnt;     // outstanding read: edges left until data
  logic [7:0]          r_idx;
  logic [31:0]         r_period;
  logic [31:0]         r_cnt;
  logic [NOTE_W-1:0]   r_note;
  logic                r_valid;
  logic                r_strobe;
  logic                r_playing;
  logic                r_done;
  logic                r_metro;

  state_t              w_state_n;
  logic [ADDR_W-1:0]   w_addr_n;
  logic [WORD_W-1:0]   w_cur_n;
  logic [WORD_W-1:0]   w_next_n;
  logic [LAT_W-1:0]    w_rd_cnt_n;
  logic [7:0]          w_idx_n;
  logic [31:0]         w_period_n;
  logic [31:0]         w_cnt_n;
  logic [NOTE_W-1:0]   w_note_n;
  logic                w_valid_n;
  logic                w_strobe_n;
  logic                w_clear;
  logic                w_rd_hit;
  logic [WORD_W-1:0]   w_word;
  logic [WORD_W-1:0]   w_fetched;

  // Next-state, datapath and output decode.
  always_comb begin
    w_state_n  = r_state;
    w_addr_n   = r_addr;
    w_cur_n    = r_cur_word;
    w_next_n   = r_next_word;
    w_idx_n    = r_idx;
    w_period_n = r_period;
    w_cnt_n    = r_cnt;
    w_note_n   = r_note;
    w_valid_n  = r_valid;
    w_strobe_n = 1'b0;
    w_clear    = 1'b0;
    w_word     = r_cur_word;

    // Read-latency countdown; the data is valid on the edge where it is 1.
    w_rd_hit = (r_rd_cnt == LAT_W'(1));
    if (r_rd_cnt != '0) begin
      w_rd_cnt_n = r_rd_cnt - LAT_W'(1);
    end else begin
      w_rd_cnt_n = r_rd_cnt;
    end

    // Prefetched word, bypassing the buffer if it lands on this very edge.
    if (w_rd_hit) begin
      w_fetched = mem_data_in;
    end else begin
      w_fetched = r_next_word;
    end

    case (r_state)
      S_IDLE: begin
        if (play_in) begin
          w_state_n  = S_FETCH;
          w_addr_n   = '0;
          w_idx_n    = 8'd0;
          w_rd_cnt_n = C_LAT;
        end else begin
          w_clear = 1'b1;
        end
      end

      S_FETCH: begin
        if (!play_in) begin
          w_clear = 1'b1;
        end else if (w_rd_hit) begin
          // First word arrives: start eighth 0 and prefetch word 1.
          w_state_n  = S_PLAY;
          w_cur_n    = mem_data_in;
          w_word     = mem_data_in;
          w_cnt_n    = 32'd0;
          w_period_n = period_sel(bpm_in);
          w_strobe_n = 1'b1;
          w_note_n   = slot_of(mem_data_in, 3'd0);
          w_valid_n  = w_note_n[NOTE_W-1];
          w_addr_n   = addr_inc(r_addr);
          w_rd_cnt_n = C_LAT;
        end else begin
          w_state_n = S_FETCH;
        end
      end

      S_PLAY: begin
        if (!play_in) begin
          // Stop has priority over a coincident eighth boundary.
          w_clear = 1'b1;
        end else begin
          if (w_rd_hit) begin
            w_next_n = mem_data_in;
          end else begin
            w_next_n = r_next_word;
          end

          if (r_cnt == r_period - 32'd1) begin
            if ((r_idx == C_LAST_IDX) && !loop_in) begin
              w_state_n = S_DONE;
              w_cnt_n   = 32'd0;
              w_note_n  = '0;
              w_valid_n = 1'b0;
            end else begin
              if (r_idx == C_LAST_IDX) begin
                w_idx_n = 8'd0;
              end else begin
                w_idx_n = r_idx + 8'd1;
              end
              w_cnt_n    = 32'd0;
              w_period_n = period_sel(bpm_in);
              w_strobe_n = 1'b1;
              if (r_idx[2:0] == 3'd7) begin
                // Crossing into a new measure: swap in the prefetched word
                // and request the one after it.
                w_word     = w_fetched;
                w_cur_n    = w_fetched;
                w_addr_n   = addr_inc(r_addr);
                w_rd_cnt_n = C_LAT;
              end else begin
                w_word = r_cur_word;
              end
              w_note_n  = slot_of(w_word, w_idx_n[2:0]);
              w_valid_n = w_note_n[NOTE_W-1];
            end
          end else begin
            w_cnt_n = r_cnt + 32'd1;
          end
        end
      end

      S_DONE: begin
        if (!play_in) begin
          w_clear = 1'b1;
        end else begin
          w_state_n = S_DONE;
        end
      end

      default: begin
        w_clear = 1'b1;
      end
    endcase

    // Return to IDLE with every buffer and output cleared.
    if (w_clear) begin
      w_state_n  = S_IDLE;
      w_addr_n   = '0;
      w_cur_n    = '0;
      w_next_n   = '0;
      w_rd_cnt_n = '0;
      w_idx_n    = 8'd0;
      w_period_n = 32'd0;
      w_cnt_n    = 32'd0;
      w_note_n   = '0;
      w_valid_n  = 1'b0;
      w_strobe_n = 1'b0;
    end else begin
      w_strobe_n = w_strobe_n;
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk_2 or posedge rst_in) begin
    if (rst_in) begin
      r_state     <= S_IDLE;
      r_addr      <= '0;
      r_cur_word  <= '0;
      r_next_word <= '0;
      r_rd_cnt    <= '0;
      r_idx       <= 8'd0;
      r_period    <= 32'd0;
      r_cnt       <= 32'd0;
      r_note      <= '0;
      r_valid     <= 1'b0;
      r_strobe    <= 1'b0;
      r_playing   <= 1'b0;
      r_done      <= 1'b0;
      r_metro     <= 1'b0;
    end else begin
      r_state     <= w_state_n;
      r_addr      <= w_addr_n;
      r_cur_word  <= w_cur_n;
      r_next_word <= w_next_n;
      r_rd_cnt    <= w_rd_cnt_n;
      r_idx       <= w_idx_n;
      r_period    <= w_period_n;
      r_cnt       <= w_cnt_n;
      r_note      <= w_note_n;
      r_valid     <= w_valid_n;
      r_strobe    <= w_strobe_n;
      r_playing   <= (w_state_n == S_PLAY);
      r_done      <= (w_state_n == S_DONE);
      r_metro     <= (w_state_n == S_PLAY) && (w_cnt_n < C_CLICK);
    end
  end

  assign mem_addr_out    = r_addr;
  assign note_out        = r_note;
  assign note_valid_out  = r_valid;
  assign note_strobe_out = r_strobe;
  assign eighth_idx_out  = r_idx;
  assign playing_out     = r_playing;
  assign done_out        = r_done;
  assign metronome_out   = r_metro;

endmodule

// File: tb/tb_note_playback_sequencer.sv
module tb_note_playback_sequencer;

  localparam int DEPTH = 2;

  logic        clk_2   = 1'b0;
  logic        rst_in  = 1'b1;
  logic        play_in = 1'b0;
  logic        loop_in = 1'b0;
  logic [1:0]  bpm_in  = 2'b10;
  logic [0:0]  mem_addr_out;
  logic [47:0] mem_data_in;
  logic [5:0]  note_out;
  logic        note_valid_out;
  logic        note_strobe_out;
  logic [7:0]  eighth_idx_out;
  logic        playing_out;
  logic        done_out;
  logic        metronome_out;

  logic [47:0] mem [0:DEPTH-1];

  int errors = 0;
  int checks = 0;

  note_playback_sequencer #(
    .MEAS_DEPTH  (DEPTH),
    .NOTE_W      (6),
    .RD_LATENCY  (2),
    .PERIOD_120  (10),
    .PERIOD_80   (20),
    .PERIOD_60   (30),
    .CLICK_CYCLES(3)
  ) dut (
    .clk_2          (clk_2),
    .rst_in         (rst_in),
    .play_in        (play_in),
    .loop_in        (loop_in),
    .bpm_in         (bpm_in),
    .mem_addr_out   (mem_addr_out),
    .mem_data_in    (mem_data_in),
    .note_out       (note_out),
    .note_valid_out (note_valid_out),
    .note_strobe_out(note_strobe_out),
    .eighth_idx_out (eighth_idx_out),
    .playing_out    (playing_out),
    .done_out       (done_out),
    .metronome_out  (metronome_out)
  );

  always #5 clk_2 = ~clk_2;

  // Two-cycle memory: address driven at edge k is sampled by the DUT at k+2.
  always @(posedge clk_2) mem_data_in <= mem[mem_addr_out];

  function automatic logic [47:0] mk_seq(input logic [5:0] base);
    logic [47:0] w;
    w = '0;
    for (int s = 0; s < 8; s++) w[s*6 +: 6] = base + 6'(s);
    return w;
  endfunction

  function automatic logic [47:0] mk_alt();
    logic [47:0] w;
    w = '0;
    for (int s = 0; s < 8; s++) w[s*6 +: 6] = (s % 2 == 0) ? 6'h05 : 6'h21;
    return w;
  endfunction

  task automatic check(input string tag, input logic [47:0] obs, input logic [47:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_2);
    #1;
  endtask

  // Advance until a strobe is seen; gap = cycles waited.
  task automatic wait_strobe(input int budget, output int gap);
    gap = 0;
    do begin
      tick();
      gap++;
    end while (!note_strobe_out && gap < budget);
    check("strobe_seen", 48'(note_strobe_out), 48'd1);
  endtask

  initial begin
    int g;
    int ns;
    mem[0] = mk_seq(6'h20);
    mem[1] = mk_seq(6'h28);

    // Reset values
    tick(); tick();
    check("rst_strobe",  48'(note_strobe_out), 48'd0);
    check("rst_note",    48'(note_out),        48'd0);
    check("rst_valid",   48'(note_valid_out),  48'd0);
    check("rst_idx",     48'(eighth_idx_out),  48'd0);
    check("rst_playing", 48'(playing_out),     48'd0);
    check("rst_done",    48'(done_out),        48'd0);
    check("rst_metro",   48'(metronome_out),   48'd0);
    check("rst_addr",    48'(mem_addr_out),    48'd0);
    rst_in = 1'b0;
    tick();

    // Basic playback
    play_in = 1'b1;
    tick();
    check("fetch_playing", 48'(playing_out), 48'd0);
    check("fetch_addr",    48'(mem_addr_out), 48'd0);
    tick();
    check("fetch_nostrobe", 48'(note_strobe_out), 48'd0);
    tick();
    check("first_strobe",  48'(note_strobe_out), 48'd1);
    check("first_note",    48'(note_out),        48'h20);
    check("first_valid",   48'(note_valid_out),  48'd1);
    check("first_idx",     48'(eighth_idx_out),  48'd0);
    check("first_playing", 48'(playing_out),     48'd1);
    check("first_metro",   48'(metronome_out),   48'd1);
    check("prefetch_addr", 48'(mem_addr_out),    48'd1);
    for (int k = 1; k < 16; k++) begin
      wait_strobe(40, g);
      check("basic_gap",  48'(g),              48'd10);
      check("basic_note", 48'(note_out),       48'(8'h20 + 8'(k)));
      check("basic_idx",  48'(eighth_idx_out), 48'(k));
    end
    repeat (10) tick();
    check("done_flag",    48'(done_out),       48'd1);
    check("done_playing", 48'(playing_out),    48'd0);
    check("done_valid",   48'(note_valid_out), 48'd0);
    check("done_note",    48'(note_out),       48'd0);
    check("done_idx",     48'(eighth_idx_out), 48'd15);
    check("done_strobe",  48'(note_strobe_out), 48'd0);
    play_in = 1'b0;
    tick();
    check("idle_done", 48'(done_out),       48'd0);
    check("idle_idx",  48'(eighth_idx_out), 48'd0);

    // Rests and metronome
    mem[0] = mk_alt();
    mem[1] = mk_alt();
    play_in = 1'b1;
    tick(); tick(); tick();
    check("rest_strobe", 48'(note_strobe_out), 48'd1);
    check("rest_note",   48'(note_out),        48'h05);
    check("rest_valid",  48'(note_valid_out),  48'd0);
    check("metro_c0",    48'(metronome_out),   48'd1);
    tick();
    check("metro_c1", 48'(metronome_out), 48'd1);
    tick();
    check("metro_c2", 48'(metronome_out), 48'd1);
    tick();
    check("metro_c3", 48'(metronome_out), 48'd0);
    wait_strobe(40, g);
    check("rest_gap",    48'(g),              48'd7);
    check("sound_note",  48'(note_out),       48'h21);
    check("sound_valid", 48'(note_valid_out), 48'd1);
    check("sound_metro", 48'(metronome_out),  48'd1);
    wait_strobe(40, g);
    check("rest2_valid", 48'(note_valid_out), 48'd0);
    play_in = 1'b0;
    tick();
    check("rest_stop_playing", 48'(playing_out), 48'd0);
    check("rest_stop_note",    48'(note_out),    48'd0);

    // Tempo change mid-eighth 3
    mem[0] = mk_seq(6'h20);
    mem[1] = mk_seq(6'h28);
    play_in = 1'b1;
    tick(); tick(); tick();
    for (int k = 1; k <= 3; k++) wait_strobe(40, g);
    check("tempo_idx3", 48'(eighth_idx_out), 48'd3);
    tick(); tick(); tick();
    bpm_in = 2'b01;
    wait_strobe(40, g);
    check("tempo_old_gap", 48'(g + 3),         48'd10);
    check("tempo_idx4",    48'(eighth_idx_out), 48'd4);
    wait_strobe(40, g);
    check("tempo_new_gap", 48'(g),              48'd20);
    check("tempo_idx5",    48'(eighth_idx_out), 48'd5);
    play_in = 1'b0;
    bpm_in  = 2'b10;
    tick();
    check("tempo_stop", 48'(playing_out), 48'd0);

    // Looping
    loop_in = 1'b1;
    play_in = 1'b1;
    tick(); tick(); tick();
    for (int k = 1; k < 16; k++) wait_strobe(40, g);
    check("loop_idx15", 48'(eighth_idx_out), 48'd15);
    wait_strobe(40, g);
    check("loop_gap",     48'(g),              48'd10);
    check("loop_idx0",    48'(eighth_idx_out), 48'd0);
    check("loop_note",    48'(note_out),       48'h20);
    check("loop_playing", 48'(playing_out),    48'd1);
    for (int k = 1; k <= 8; k++) wait_strobe(40, g);
    check("loop_idx8",  48'(eighth_idx_out), 48'd8);
    check("loop_note8", 48'(note_out),       48'h28);
    loop_in = 1'b0;
    play_in = 1'b0;
    tick();

    // Stop mid-play and restart
    play_in = 1'b1;
    tick(); tick(); tick();
    for (int k = 1; k <= 5; k++) wait_strobe(40, g);
    check("stop_idx5", 48'(eighth_idx_out), 48'd5);
    repeat (4) tick();
    play_in = 1'b0;
    tick();
    check("stop_playing", 48'(playing_out),     48'd0);
    check("stop_note",    48'(note_out),        48'd0);
    check("stop_valid",   48'(note_valid_out),  48'd0);
    check("stop_idx",     48'(eighth_idx_out),  48'd0);
    check("stop_strobe",  48'(note_strobe_out), 48'd0);
    ns = 0;
    repeat (40) begin
      tick();
      if (note_strobe_out) ns++;
    end
    check("stop_no_strobes", 48'(ns), 48'd0);
    play_in = 1'b1;
    tick(); tick(); tick();
    check("restart_strobe", 48'(note_strobe_out), 48'd1);
    check("restart_idx",    48'(eighth_idx_out),  48'd0);
    check("restart_note",   48'(note_out),        48'h20);

    // Stop coinciding with an eighth boundary
    repeat (9) tick();
    play_in = 1'b0;
    tick();
    check("coinc_strobe",  48'(note_strobe_out), 48'd0);
    check("coinc_playing", 48'(playing_out),     48'd0);
    tick();

    // Asynchronous reset mid-play
    play_in = 1'b1;
    tick(); tick(); tick();
    wait_strobe(40, g);
    wait_strobe(40, g);
    check("pre_rst_note", 48'(note_out), 48'h22);
    tick(); tick();
    #3 rst_in = 1'b1;
    #1;
    check("arst_note",    48'(note_out),        48'd0);
    check("arst_valid",   48'(note_valid_out),  48'd0);
    check("arst_playing", 48'(playing_out),     48'd0);
    check("arst_idx",     48'(eighth_idx_out),  48'd0);
    check("arst_addr",    48'(mem_addr_out),    48'd0);
    check("arst_metro",   48'(metronome_out),   48'd0);
    check("arst_strobe",  48'(note_strobe_out), 48'd0);
    #1 rst_in = 1'b0;
    play_in = 1'b0;
    tick();
    check("arst_idle_playing", 48'(playing_out), 48'd0);
    check("arst_idle_done",    48'(done_out),    48'd0);
    play_in = 1'b1;
    tick(); tick(); tick();
    check("arst_restart_strobe", 48'(note_strobe_out), 48'd1);
    check("arst_restart_note",   48'(note_out),        48'h20);
    play_in = 1'b0;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
